seven_seg_scanner: RTL and testbench
====================================

Name: seven_seg_scanner

Overview:
- Output-side display driver for the digital alarm clock.
- Takes the four BCD time digits plus decimal points and blink/blank controls from the clock core, and time-multiplexes them onto one shared 7-segment bus with one-hot digit enables.
- Its outputs map directly onto the chip's dedicated output pins.
- Inserts a dead-time between digits to prevent ghosting, and snapshots inputs once per frame to prevent tearing.

Parameters:
- SCAN_DIV, 10000, clock cycles per digit slot; must be ≥2.
- BLANK_CYCLES, 16, dead-time cycles at the start of each slot; must be < SCAN_DIV.
- SEG_ACTIVE_LOW, 0, 1 inverts seg_o and dp_o at the output register.
- DIG_ACTIVE_LOW, 0, 1 inverts dig_o at the output register.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- ena  in  1  scan enable; low forces the display off.
- digits_i  in  16  four BCD nibbles; [3:0] is digit0 (rightmost), [15:12] is digit3.
- dp_i  in  4  decimal point per digit.
- blink_mask_i  in  4  digits subject to blinking.
- blink_phase_i  in  1  1 hides the masked digits.
- lz_blank_i  in  1  blank digit3 when its value is 0.
- seg_o  out  7  segments; bit0=a … bit6=g.
- dp_o  out  1  decimal point.
- dig_o  out  4  one-hot digit enable.
- frame_o  out  1  one-cycle pulse at the start of each frame.

Behaviour:
- Clocking/reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- While rst_n is low, all outputs are at their inactive level:
  - seg_o and dp_o are 0, or all-1s if SEG_ACTIVE_LOW.
  - dig_o is 0, or 4'hF if DIG_ACTIVE_LOW.
  - frame_o is 0.
  - Internal idx=0, cnt=0, snapshot=0.
- All outputs are registered. No combinational input-to-output path.
- Counters:
  - cnt runs 0..SCAN_DIV-1, then wraps to 0 and increments idx.
  - idx runs 0..3 and wraps 3→0.
  - Counters only advance while ena=1.
- Snapshot: on the edge where ena=1, idx=0 and cnt=0, register digits_i, dp_i, blink_mask_i, blink_phase_i and lz_blank_i. frame_o=1 in the following cycle only.
- Slot timing:
  - While cnt < BLANK_CYCLES (BLANK phase): dig_o and seg_o are inactive.
  - While cnt ≥ BLANK_CYCLES (SHOW phase): dig_o has bit idx active; seg_o/dp_o carry the decoded snapshot digit idx.
  - Output registers lag cnt by exactly one cycle, so dig_o first goes active BLANK_CYCLES cycles after frame_o rises.
- Decode: 0–9 use standard patterns (0=0x3F, 1=0x06, 2=0x5B, 3=0x4F, 4=0x66, 5=0x6D, 6=0x7D, 7=0x07, 8=0x7F, 9=0x6F). 0xA–0xE show dash (0x40). 0xF shows blank (0x00).
- Suppression (segments and dp forced off, dig_o still timed normally):
  - Leading zero: lz_blank=1 and digit3==0.
  - Blink: blink_mask[idx]=1 and blink_phase=1.
- ena low:
  - On the next edge, all outputs go inactive, and idx and cnt reset to 0.
  - On re-assertion, the first edge takes a fresh snapshot and frame_o pulses the cycle after, i.e. the same as after reset.
- Reset mid-slot: outputs go inactive immediately (asynchronously). Scanning restarts at digit0 with a snapshot.
- Input changes mid-frame never affect the display until the next snapshot.

Decomposition:
- Package seven_seg_pkg holds:
  - the segment-pattern constants (SEG_0…SEG_9, SEG_DASH, SEG_BLANK);
  - the bit-index constants for a–g;
  - a localparam for NUM_DIGITS=4.
- One combinational sub-module, bcd_to_seg (4-bit in, 7-bit out), implements the decode table. It is instantiated once on the muxed snapshot digit.
- Polarity inversion and suppression live in seven_seg_scanner.

Test Plan (SCAN_DIV=8, BLANK_CYCLES=2 unless noted):
1. Hold rst_n=0 → seg_o=0x00, dp_o=0, dig_o=0x0, frame_o=0. Release with ena=0 → outputs unchanged for 50 cycles.
2. digits_i=0x1234, ena=1 → frame_o pulses every 32 cycles. dig_o sequence per frame is 0001,0010,0100,1000, each active 6 cycles after 2 off. seg_o is 0x66, 0x4F, 0x5B, 0x06 respectively.
3. digits_i changed 0x1234→0x5678 during idx=1 → rest of frame still shows 3/2/1. After the next frame_o, digit0 shows 0x7F (8).
4. digits_i=0x093F, lz_blank=1, dp_i=0100, blink_mask=0010, blink_phase=1:
   - digit0 seg 0x00 (value F);
   - digit1 seg 0x00 (blinked);
   - digit2 seg 0x6F with dp_o=1;
   - digit3 seg 0x00 (leading zero);
   - dig_o timing unchanged throughout.
5. Drop ena mid-SHOW of digit2 → next cycle all outputs inactive. Re-raise ena → frame_o pulses after one edge; digit0 is first shown 2 cycles later.
6. SEG_ACTIVE_LOW=1, DIG_ACTIVE_LOW=1: reset → seg_o=0x7F, dp_o=1, dig_o=0xF. digits_i=0x0000 → digit0 SHOW gives seg_o=0x40, dig_o=0xE.

Source files
------------

// File: rtl/seven_seg_pkg.sv
// Shared definitions for the multiplexed 7-segment display driver.
//   - NUM_DIGITS        : number of digit positions on the display
//   - SEG_A .. SEG_G    : bit positions of each segment on the segment bus
//   - SEG_0 .. SEG_9,
//     SEG_DASH, SEG_BLANK : active-high segment patterns
//   - snap_t            : per-frame snapshot of the display inputs
package seven_seg_pkg;

    localparam int NUM_DIGITS = 4;

    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;

    function automatic logic [6:0] seg_bit(input int i);
        return 7'(1) << i;
    endfunction

    localparam logic [6:0] SEG_0 = seg_bit(SEG_A) | seg_bit(SEG_B) | seg_bit(SEG_C) |
                                   seg_bit(SEG_D) | seg_bit(SEG_E) | seg_bit(SEG_F);
    localparam logic [6:0] SEG_1 = seg_bit(SEG_B) | seg_bit(SEG_C);
    localparam logic [6:0] SEG_2 = seg_bit(SEG_A) | seg_bit(SEG_B) | seg_bit(SEG_D) |
                                   seg_bit(SEG_E) | seg_bit(SEG_G);
    localparam logic [6:0] SEG_3 = seg_bit(SEG_A) | seg_bit(SEG_B) | seg_bit(SEG_C) |
                                   seg_bit(SEG_D) | seg_bit(SEG_G);
    localparam logic [6:0] SEG_4 = seg_bit(SEG_B) | seg_bit(SEG_C) | seg_bit(SEG_F) |
                                   seg_bit(SEG_G);
    localparam logic [6:0] SEG_5 = seg_bit(SEG_A) | seg_bit(SEG_C) | seg_bit(SEG_D) |
                                   seg_bit(SEG_F) | seg_bit(SEG_G);
    localparam logic [6:0] SEG_6 = seg_bit(SEG_A) | seg_bit(SEG_C) | seg_bit(SEG_D) |
                                   seg_bit(SEG_E) | seg_bit(SEG_F) | seg_bit(SEG_G);
    localparam logic [6:0] SEG_7 = seg_bit(SEG_A) | seg_bit(SEG_B) | seg_bit(SEG_C);
    localparam logic [6:0] SEG_8 = SEG_0 | seg_bit(SEG_G);
    localparam logic [6:0] SEG_9 = seg_bit(SEG_A) | seg_bit(SEG_B) | seg_bit(SEG_C) |
                                   seg_bit(SEG_D) | seg_bit(SEG_F) | seg_bit(SEG_G);
    localparam logic [6:0] SEG_DASH  = seg_bit(SEG_G);
    localparam logic [6:0] SEG_BLANK = 7'h00;

    typedef struct packed {
        logic [4*NUM_DIGITS-1:0] digits;
        logic [NUM_DIGITS-1:0]   dp;
        logic [NUM_DIGITS-1:0]   blink_mask;
        logic                    blink_phase;
        logic                    lz_blank;
    } snap_t;

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational BCD to 7-segment decoder (active-high patterns).
//   i_bcd : 4-bit digit value; 0-9 decode normally, A-E show a dash, F is blank
//   o_seg : segment pattern, bit0 = a ... bit6 = g
module bcd_to_seg
    import seven_seg_pkg::*;
(
    input  logic [3:0] i_bcd,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_DASH;
        case (i_bcd)
            4'd0: o_seg = SEG_0;
            4'd1: o_seg = SEG_1;
            4'd2: o_seg = SEG_2;
            4'd3: o_seg = SEG_3;
            4'd4: o_seg = SEG_4;
            4'd5: o_seg = SEG_5;
            4'd6: o_seg = SEG_6;
            4'd7: o_seg = SEG_7;
            4'd8: o_seg = SEG_8;
            4'd9: o_seg = SEG_9;
            4'hF: o_seg = SEG_BLANK;
            default: o_seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed 7-segment display driver for the alarm clock.
// Each digit gets a slot of SCAN_DIV cycles; the first BLANK_CYCLES of each slot
// are dead-time with everything off to avoid ghosting. All inputs are captured
// once per frame (at the start of digit0's slot) so a frame never tears.
//   clk, rst_n      : clock, asynchronous active-low reset
//   ena             : scan enable; low drives the display off and restarts the scan
//   digits_i        : four BCD nibbles, [3:0] is the rightmost digit
//   dp_i            : decimal point per digit
//   blink_mask_i    : digits hidden while blink_phase_i is 1
//   blink_phase_i   : blink phase
//   lz_blank_i      : hide the leftmost digit when it is 0
//   seg_o, dp_o     : segment bus and decimal point (registered)
//   dig_o           : one-hot digit enable (registered)
//   frame_o         : one-cycle pulse after each snapshot
module seven_seg_scanner
    import seven_seg_pkg::*;
#(
    parameter int SCAN_DIV       = 10000,
    parameter int BLANK_CYCLES   = 16,
    parameter bit SEG_ACTIVE_LOW = 1'b0,
    parameter bit DIG_ACTIVE_LOW = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    ena,
    input  logic [4*NUM_DIGITS-1:0] digits_i,
    input  logic [NUM_DIGITS-1:0]   dp_i,
    input  logic [NUM_DIGITS-1:0]   blink_mask_i,
    input  logic                    blink_phase_i,
    input  logic                    lz_blank_i,
    output logic [6:0]              seg_o,
    output logic                    dp_o,
    output logic [NUM_DIGITS-1:0]   dig_o,
    output logic                    frame_o
);

    localparam int CW = $clog2(SCAN_DIV);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam logic [CW-1:0] CNT_MAX   = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] BLANK_LIM = CW'(BLANK_CYCLES);
    localparam logic [IW-1:0] IDX_MAX   = IW'(NUM_DIGITS - 1);

    // Inactive output levels double as XOR masks for polarity inversion.
    localparam logic [6:0]            SEG_OFF = {7{SEG_ACTIVE_LOW}};
    localparam logic                  DP_OFF  = SEG_ACTIVE_LOW;
    localparam logic [NUM_DIGITS-1:0] DIG_OFF = {NUM_DIGITS{DIG_ACTIVE_LOW}};

    logic [CW-1:0]         r_cnt;
    logic [IW-1:0]         r_idx;
    snap_t                 r_snap;
    logic [6:0]            r_seg;
    logic                  r_dp;
    logic [NUM_DIGITS-1:0] r_dig;
    logic                  r_frame;

    snap_t                 w_in;
    snap_t                 w_cur;
    logic                  w_take_snap;
    logic                  w_show;
    logic                  w_suppress;
    logic [3:0]            w_nibble;
    logic [6:0]            w_seg_raw;
    logic [6:0]            w_seg_on;
    logic                  w_dp_on;
    logic [NUM_DIGITS-1:0] w_dig_on;

    assign w_in        = {digits_i, dp_i, blink_mask_i, blink_phase_i, lz_blank_i};
    assign w_take_snap = ena && (r_idx == '0) && (r_cnt == '0);

    // On the snapshot edge the register still holds the previous frame, so
    // decode from the incoming values; this only matters when BLANK_CYCLES=0.
    assign w_cur = w_take_snap ? w_in : r_snap;

    assign w_show   = (r_cnt >= BLANK_LIM);
    assign w_nibble = w_cur.digits[{r_idx, 2'b00} +: 4];

    bcd_to_seg u_dec (
        .i_bcd (w_nibble),
        .o_seg (w_seg_raw)
    );

    assign w_suppress = (w_cur.blink_mask[r_idx] && w_cur.blink_phase) ||
                        (w_cur.lz_blank && (r_idx == IDX_MAX) &&
                         (w_cur.digits[4*NUM_DIGITS-1 -: 4] == 4'h0));

    assign w_seg_on = (w_show && !w_suppress) ? w_seg_raw : 7'h00;
    assign w_dp_on  = w_show && !w_suppress && w_cur.dp[r_idx];
    assign w_dig_on = w_show ? (NUM_DIGITS'(1) << r_idx) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_idx <= '0;
        end else if (!ena) begin
            r_cnt <= '0;
            r_idx <= '0;
        end else if (r_cnt == CNT_MAX) begin
            r_cnt <= '0;
            r_idx <= (r_idx == IDX_MAX) ? '0 : r_idx + 1'b1;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_snap <= '0;
        end else if (w_take_snap) begin
            r_snap <= w_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seg   <= SEG_OFF;
            r_dp    <= DP_OFF;
            r_dig   <= DIG_OFF;
            r_frame <= 1'b0;
        end else if (!ena) begin
            r_seg   <= SEG_OFF;
            r_dp    <= DP_OFF;
            r_dig   <= DIG_OFF;
            r_frame <= 1'b0;
        end else begin
            r_seg   <= w_seg_on ^ SEG_OFF;
            r_dp    <= w_dp_on ^ DP_OFF;
            r_dig   <= w_dig_on ^ DIG_OFF;
            r_frame <= w_take_snap;
        end
    end

    assign seg_o   = r_seg;
    assign dp_o    = r_dp;
    assign dig_o   = r_dig;
    assign frame_o = r_frame;

endmodule

// File: tb/tb_seven_seg_scanner.sv
module tb_seven_seg_scanner;

    localparam int SD = 8;
    localparam int BC = 2;
    localparam int FRAME = 4 * SD;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ena = 1'b0;
    logic [15:0] digits = 16'h0;
    logic [3:0]  dp = 4'h0;
    logic [3:0]  bmask = 4'h0;
    logic        bphase = 1'b0;
    logic        lz = 1'b0;

    logic [6:0]  seg_h;
    logic        dp_h;
    logic [3:0]  dig_h;
    logic        frame_h;
    logic [6:0]  seg_l;
    logic        dp_l;
    logic [3:0]  dig_l;
    logic        frame_l;

    int checks = 0;
    int errors = 0;

    // Reference model state: position within the frame and captured inputs.
    int          pos = 0;
    logic [15:0] s_digits;
    logic [3:0]  s_dp, s_bm;
    logic        s_bp, s_lz;
    logic [6:0]  exp_seg;
    logic        exp_dp;
    logic [3:0]  exp_dig;
    logic        exp_frame;

    always #5 clk = ~clk;

    seven_seg_scanner #(
        .SCAN_DIV(SD), .BLANK_CYCLES(BC), .SEG_ACTIVE_LOW(1'b0), .DIG_ACTIVE_LOW(1'b0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .digits_i(digits), .dp_i(dp),
        .blink_mask_i(bmask), .blink_phase_i(bphase), .lz_blank_i(lz),
        .seg_o(seg_h), .dp_o(dp_h), .dig_o(dig_h), .frame_o(frame_h)
    );

    seven_seg_scanner #(
        .SCAN_DIV(SD), .BLANK_CYCLES(BC), .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b1)
    ) dut_al (
        .clk(clk), .rst_n(rst_n), .ena(ena), .digits_i(digits), .dp_i(dp),
        .blink_mask_i(bmask), .blink_phase_i(bphase), .lz_blank_i(lz),
        .seg_o(seg_l), .dp_o(dp_l), .dig_o(dig_l), .frame_o(frame_l)
    );

    function automatic logic [6:0] decode(input logic [3:0] v);
        case (v)
            4'd0: return 7'h3F;
            4'd1: return 7'h06;
            4'd2: return 7'h5B;
            4'd3: return 7'h4F;
            4'd4: return 7'h66;
            4'd5: return 7'h6D;
            4'd6: return 7'h7D;
            4'd7: return 7'h07;
            4'd8: return 7'h7F;
            4'd9: return 7'h6F;
            4'hF: return 7'h00;
            default: return 7'h40;
        endcase
    endfunction

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic model_off();
        pos       = 0;
        exp_seg   = 7'h00;
        exp_dp    = 1'b0;
        exp_dig   = 4'h0;
        exp_frame = 1'b0;
    endtask

    // Advance the model by one clock edge using the inputs present at that edge.
    task automatic model_edge();
        int d, w;
        logic [3:0] nib;
        logic sup;
        if (!rst_n || !ena) begin
            model_off();
        end else begin
            if (pos == 0) begin
                s_digits = digits; s_dp = dp; s_bm = bmask; s_bp = bphase; s_lz = lz;
            end
            d = pos / SD;
            w = pos % SD;
            exp_frame = (pos == 0);
            if (w >= BC) begin
                nib     = 4'((s_digits >> (4 * d)) & 16'hF);
                sup     = (s_bm[d] && s_bp) || (d == 3 && s_lz && nib == 4'h0);
                exp_dig = 4'(1 << d);
                exp_seg = sup ? 7'h00 : decode(nib);
                exp_dp  = sup ? 1'b0 : s_dp[d];
            end else begin
                exp_dig = 4'h0;
                exp_seg = 7'h00;
                exp_dp  = 1'b0;
            end
            pos = (pos + 1) % FRAME;
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".seg"},   16'(seg_h),   16'(exp_seg));
        check({tag, ".dp"},    16'(dp_h),    16'(exp_dp));
        check({tag, ".dig"},   16'(dig_h),   16'(exp_dig));
        check({tag, ".frame"}, 16'(frame_h), 16'(exp_frame));
        check({tag, ".al"}, 16'({seg_l, dp_l, dig_l, frame_l}),
              16'({exp_seg ^ 7'h7F, ~exp_dp, exp_dig ^ 4'hF, exp_frame}));
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all(tag);
    endtask

    initial begin
        bit saw_frame;

        // 1. Reset state, then idle with ena low.
        model_off();
        repeat (3) @(negedge clk);
        check_all("reset");
        check("reset_al_seg", 16'(seg_l), 16'h7F);
        check("reset_al_dig", 16'(dig_l), 16'hF);
        check("reset_al_dp", 16'(dp_l), 16'h1);
        rst_n = 1'b1;
        for (int i = 0; i < 50; i++) tick("idle");

        // 2. Normal scanning of 1234.
        digits = 16'h1234;
        ena = 1'b1;
        tick("t2_first");
        check("t2_frame_first", 16'(frame_h), 16'h1);
        for (int i = 1; i < 2 * FRAME + 4; i++) begin
            tick("t2");
            if (exp_dig == 4'b0001) check("t2_digit0_4", 16'(seg_h), 16'h66);
            if (exp_dig == 4'b1000) check("t2_digit3_1", 16'(seg_h), 16'h06);
        end

        // 3. Change inputs mid-frame during digit1.
        for (int i = 0; i < FRAME && exp_dig != 4'b0010; i++) tick("t3_seek");
        check("t3_reach_digit1", 16'(dig_h), 16'h2);
        digits = 16'h5678;
        saw_frame = 1'b0;
        for (int i = 0; i < FRAME + 4; i++) begin
            tick("t3");
            if (exp_frame) saw_frame = 1'b1;
            if (!saw_frame && exp_dig == 4'b0100) check("t3_old_digit2", 16'(seg_h), 16'h5B);
            if (saw_frame && exp_dig == 4'b0001) check("t3_new_digit0", 16'(seg_h), 16'h7F);
        end

        // 4. Suppression: value F, blink, dp, leading zero.
        digits = 16'h093F; lz = 1'b1; dp = 4'b0100; bmask = 4'b0010; bphase = 1'b1;
        for (int i = 0; i < FRAME + 1 && !exp_frame; i++) tick("t4_seek");
        check("t4_frame", 16'(frame_h), 16'h1);
        for (int i = 0; i < FRAME; i++) begin
            tick("t4");
            case (exp_dig)
                4'b0001: check("t4_digitF", 16'(seg_h), 16'h00);
                4'b0010: check("t4_blink", 16'(seg_h), 16'h00);
                4'b0100: check("t4_digit9dp", 16'({seg_h, dp_h}), 16'({7'h6F, 1'b1}));
                4'b1000: check("t4_lz", 16'(seg_h), 16'h00);
                default: ;
            endcase
        end

        // 5/6. Drop ena during digit2 SHOW, re-raise with all-zero digits.
        for (int i = 0; i < FRAME && exp_dig != 4'b0100; i++) tick("t5_seek");
        check("t5_reach_digit2", 16'(dig_h), 16'h4);
        ena = 1'b0;
        tick("t5_off");
        check("t5_off_dig", 16'(dig_h), 16'h0);
        for (int i = 0; i < 5; i++) tick("t5_idle");
        digits = 16'h0000; dp = 4'h0; bmask = 4'h0; bphase = 1'b0; lz = 1'b0;
        ena = 1'b1;
        tick("t5_on1");
        check("t5_frame", 16'(frame_h), 16'h1);
        tick("t5_on2");
        check("t5_still_blank", 16'(dig_h), 16'h0);
        tick("t5_on3");
        check("t5_digit0", 16'(dig_h), 16'h1);
        check("t6_al_seg", 16'(seg_l), 16'h40);
        check("t6_al_dig", 16'(dig_l), 16'hE);

        // Randomized run against the model, with ena drops and async resets.
        for (int i = 0; i < 1500; i++) begin
            digits = 16'($urandom);
            if ($urandom_range(0, 7) == 0) begin
                dp = 4'($urandom); bmask = 4'($urandom);
                bphase = 1'($urandom); lz = 1'($urandom);
            end
            if ($urandom_range(0, 3) == 0) digits[15:12] = 4'h0;
            if (ena) ena = ($urandom_range(0, 79) != 0);
            else     ena = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 249) == 0) begin
                #2 rst_n = 1'b0;
                #1 model_off();
                check_all("rnd_async_rst");
                tick("rnd_in_rst");
                rst_n = 1'b1;
            end
            tick("rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
